// File: rtl/sevenseg_pkg.sv
// Shared segment codes and scan FSM encoding for the seven-segment scan driver.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

endpackage

// File: rtl/sevenseg_scan_driver_hex_to_seg.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed 8-digit common-anode display driver with per-frame input snapshot.
// Optional leading-zero suppression when SEVENSEG_LZ_BLANK_EN is defined.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_CNT  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [4*N_DIGITS-1:0] HEX_IN,
  input  logic [N_DIGITS-1:0]   DP_IN,
  input  logic                  EN,
  output logic [N_DIGITS-1:0]   ANODE,
  output logic [6:0]            CATHODE,
  output logic                  DP,
  output logic                  FRAME_START
);

  localparam int CW = $clog2(REFRESH_CNT);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_CNT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam state_t        SLOT_FIRST = (BLANK_CYCLES > 0) ? BLANK : SHOW;
  localparam logic [N_DIGITS-1:0] ONE_HOT0 = N_DIGITS'(1);

  state_t                       state;
  logic [IW-1:0]                idx;
  logic [CW-1:0]                cnt;
  logic [N_DIGITS-1:0][3:0]     shadow_hex;
  logic [N_DIGITS-1:0]          shadow_dp;
  logic [6:0]                   seg;
  logic                         capture;
  logic                         digit_on;

  hex_to_seg u_dec (
    .nibble (shadow_hex[idx]),
    .seg    (seg)
  );

  // Snapshot on leaving IDLE and on the edge that ends the last digit's slot.
  assign capture = (state == IDLE) ||
                   ((state != IDLE) && (cnt == CNT_LAST) && (idx == IDX_LAST));

`ifdef SEVENSEG_LZ_BLANK_EN
  logic [IW-1:0] top_idx, top_idx_d;

  always_comb begin
    top_idx_d = '0;
    for (int i = 1; i < N_DIGITS; i++)
      if (HEX_IN[4*i +: 4] != 4'h0) top_idx_d = IW'(i);
  end

  assign digit_on = (idx <= top_idx);

  always_ff @(posedge CLK) begin
    if (!RESETN)              top_idx <= '0;
    else if (EN && capture)   top_idx <= top_idx_d;
  end
`else
  assign digit_on = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      shadow_hex  <= '0;
      shadow_dp   <= '0;
      ANODE       <= '1;
      CATHODE     <= SEG_BLANK;
      DP          <= 1'b1;
      FRAME_START <= 1'b0;
    end else if (!EN) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      ANODE       <= '1;
      CATHODE     <= SEG_BLANK;
      DP          <= 1'b1;
      FRAME_START <= 1'b0;
    end else begin
      // Outputs follow the state held before this edge.
      ANODE       <= '1;
      CATHODE     <= SEG_BLANK;
      DP          <= 1'b1;
      FRAME_START <= (state != IDLE) && (idx == '0) && (cnt == '0);
      if (state == SHOW && digit_on) begin
        ANODE   <= ~(ONE_HOT0 << idx);
        CATHODE <= seg;
        DP      <= ~shadow_dp[idx];
      end

      if (capture) begin
        shadow_hex <= HEX_IN;
        shadow_dp  <= DP_IN;
      end

      case (state)
        IDLE: begin
          state <= SLOT_FIRST;
          idx   <= '0;
          cnt   <= '0;
        end
        BLANK, SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= SLOT_FIRST;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (state == BLANK && cnt == BLANK_LAST) state <= SHOW;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver (N_DIGITS=8, REFRESH_CNT=4, BLANK_CYCLES=1).
module tb_sevenseg_scan_driver;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic [31:0] HEX_IN;
  logic [7:0]  DP_IN;
  logic        EN;
  logic [7:0]  ANODE;
  logic [6:0]  CATHODE;
  logic        DP;
  logic        FRAME_START;

  int errors = 0;
  int checks = 0;

  sevenseg_scan_driver #(.N_DIGITS(8), .REFRESH_CNT(4), .BLANK_CYCLES(1)) dut (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .HEX_IN      (HEX_IN),
    .DP_IN       (DP_IN),
    .EN          (EN),
    .ANODE       (ANODE),
    .CATHODE     (CATHODE),
    .DP          (DP),
    .FRAME_START (FRAME_START)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] ea, input logic [6:0] ec,
                     input logic ed, input logic ef);
    checks++;
    assert (ANODE === ea) else begin
      errors++; $error("FAIL %s ANODE got %h want %h", tag, ANODE, ea);
    end
    checks++;
    assert (CATHODE === ec) else begin
      errors++; $error("FAIL %s CATHODE got %h want %h", tag, CATHODE, ec);
    end
    checks++;
    assert (DP === ed) else begin
      errors++; $error("FAIL %s DP got %b want %b", tag, DP, ed);
    end
    checks++;
    assert (FRAME_START === ef) else begin
      errors++; $error("FAIL %s FRAME_START got %b want %b", tag, FRAME_START, ef);
    end
  endtask

  // Steps n cycles of a frame whose snapshot is hx/dpv; at step chg drives new inputs.
  task automatic run_frame(input string tag, input logic [31:0] hx, input logic [7:0] dpv,
                           input int n, input int chg,
                           input logic [31:0] nhx, input logic [7:0] ndp);
    int top;
    top = 7;
`ifdef SEVENSEG_LZ_BLANK_EN
    top = 0;
    for (int i = 1; i < 8; i++) if (hx[4*i +: 4] != 4'h0) top = i;
`endif
    for (int j = 0; j < n; j++) begin
      int slot, ph;
      logic [7:0] ea;
      logic [6:0] ec;
      logic       ed;
      logic [3:0] nib;
      tick();
      slot = j / 4;
      ph   = j % 4;
      ea = 8'hFF; ec = 7'h7F; ed = 1'b1;
      if (ph != 0 && slot <= top) begin
        ea  = ~(8'h01 << slot);
        nib = hx[4*slot +: 4];
        ec  = exp_seg(nib);
        ed  = ~dpv[slot];
      end
      chk($sformatf("%s j=%0d", tag, j), ea, ec, ed, (j == 0));
      if (j == chg) begin
        HEX_IN = nhx;
        DP_IN  = ndp;
      end
    end
  endtask

  initial begin
    RESETN = 1'b0;
    EN     = 1'b1;
    HEX_IN = 32'h76543210;
    DP_IN  = 8'h00;

    tick();
    chk("reset1", 8'hFF, 7'h7F, 1'b1, 1'b0);
    tick();
    chk("reset2", 8'hFF, 7'h7F, 1'b1, 1'b0);

    RESETN = 1'b1;
    tick();
    chk("leave_idle", 8'hFF, 7'h7F, 1'b1, 1'b0);

    // Scan order; HEX_IN changes mid-frame and only shows up next frame.
    run_frame("scan", 32'h76543210, 8'h00, 32, 10, 32'h11111111, 8'h00);
    // Change during digit-3 SHOW (j=13).
    run_frame("snap1", 32'h11111111, 8'h00, 32, 13, 32'h22222222, 8'h00);
    run_frame("snap2", 32'h22222222, 8'h00, 32, 5, 32'h76543210, 8'h04);
    run_frame("dp", 32'h76543210, 8'h04, 32, -1, 32'h0, 8'h0);

    // Enable drop during digit-5 SHOW (j=21).
    run_frame("pre_drop", 32'h76543210, 8'h04, 22, -1, 32'h0, 8'h0);
    EN     = 1'b0;
    HEX_IN = 32'h000000A5;
    DP_IN  = 8'h00;
    tick();
    chk("en_drop", 8'hFF, 7'h7F, 1'b1, 1'b0);
    tick();
    chk("en_idle", 8'hFF, 7'h7F, 1'b1, 1'b0);
    EN = 1'b1;
    tick();
    chk("en_restart", 8'hFF, 7'h7F, 1'b1, 1'b0);
    run_frame("lz", 32'h000000A5, 8'h00, 32, -1, 32'h0, 8'h0);

    // Reset mid-operation, during digit-1 SHOW.
    run_frame("pre_rst", 32'h000000A5, 8'h00, 6, -1, 32'h0, 8'h0);
    RESETN = 1'b0;
    tick();
    chk("mid_reset", 8'hFF, 7'h7F, 1'b1, 1'b0);
    RESETN = 1'b1;
    tick();
    chk("post_reset0", 8'hFF, 7'h7F, 1'b1, 1'b0);
    tick();
    chk("post_reset1", 8'hFF, 7'h7F, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
